// File: rtl/spi_dual_cs_master.sv
// spi_dual_cs_master: mode-0 SPI initiator, 8-bit address frame on spi_cs_addr then 16-bit data frame on spi_cs_data; `define ADDR_SKIP_EN to reuse a repeated address frame
module spi_dual_cs_master #(
  parameter int HALF_DIV = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        spi_scl,
  output logic        spi_sdi,
  output logic        spi_cs_addr,
  output logic        spi_cs_data,
  input  logic        spi_sdo
);
  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_SHIFT, A_HOLD, A_GAP, D_SETUP, D_SHIFT, D_HOLD, D_GAP, DONE
  } state_t;
  localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
  localparam logic [15:0] HIGH_END  = 16'(HALF_DIV - 1);
  localparam logic [15:0] BIT_END   = 16'(2 * HALF_DIV - 1);
  localparam logic [15:0] GAP_END   = 16'(CS_GAP - 1);
  state_t      r_state;
  logic [15:0] r_cnt, r_tx, r_rx, r_wdata, r_rdata;
  logic [3:0]  r_bit;
  logic        r_rw, r_scl, r_sdi, r_cs_a, r_cs_d, r_busy, r_rsp;
  logic        w_accept, w_skip;
  logic [3:0]  w_last_bit;
  logic [7:0]  w_abyte;
  logic [15:0] w_wdata;
`ifdef ADDR_SKIP_EN
  logic [7:0]  r_last_addr;
  logic        r_last_ok;
  assign w_skip = r_last_ok && (w_abyte == r_last_addr);
`else
  assign w_skip = 1'b0;
`endif
  assign cmd_ready   = (r_state == IDLE) && !rst;
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_abyte     = {cmd_rw, cmd_addr};
  assign w_wdata     = cmd_rw ? 16'h0000 : cmd_wdata;
  assign w_last_bit  = (r_state == D_SHIFT) ? 4'd15 : 4'd7;
  assign rsp_valid   = r_rsp;
  assign rsp_rdata   = r_rdata;
  assign busy        = r_busy;
  assign spi_scl     = r_scl;
  assign spi_sdi     = r_sdi;
  assign spi_cs_addr = r_cs_a;
  assign spi_cs_data = r_cs_d;
  // frame sequencer: every output is registered and set on the edge that enters the state it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rw    <= 1'b0;
      r_scl   <= 1'b0;
      r_sdi   <= 1'b0;
      r_cs_a  <= 1'b1;
      r_cs_d  <= 1'b1;
      r_busy  <= 1'b0;
      r_rsp   <= 1'b0;
`ifdef ADDR_SKIP_EN
      r_last_addr <= '0;
      r_last_ok   <= 1'b0;
`endif
    end else begin
      r_rsp <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_rw    <= cmd_rw;
          r_wdata <= w_wdata;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
          r_bit   <= '0;
`ifdef ADDR_SKIP_EN
          r_last_addr <= w_abyte;
          r_last_ok   <= 1'b1;
`endif
          if (w_skip) begin
            r_state <= D_SETUP;
            r_cs_d  <= 1'b0;
            r_tx    <= w_wdata;
            r_sdi   <= w_wdata[15];
          end else begin
            r_state <= A_SETUP;
            r_cs_a  <= 1'b0;
            r_tx    <= {w_abyte, 8'h00};
            r_sdi   <= cmd_rw;
          end
        end
        A_SETUP, D_SETUP: if (r_cnt == SETUP_END) begin
          r_cnt   <= '0;
          r_scl   <= 1'b1;
          r_state <= (r_state == A_SETUP) ? A_SHIFT : D_SHIFT;
          if (r_state == D_SETUP) r_rx <= {r_rx[14:0], spi_sdo};
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
        A_SHIFT, D_SHIFT: if (r_cnt == HIGH_END) begin
          r_cnt <= r_cnt + 16'd1;
          r_scl <= 1'b0;
          r_tx  <= {r_tx[14:0], 1'b0};
          r_sdi <= r_tx[14];
        end else if (r_cnt == BIT_END) begin
          r_cnt <= '0;
          if (r_bit == w_last_bit) begin
            r_bit   <= '0;
            r_state <= (r_state == A_SHIFT) ? A_HOLD : D_HOLD;
          end else begin
            r_bit <= r_bit + 4'd1;
            r_scl <= 1'b1;
            if (r_state == D_SHIFT) r_rx <= {r_rx[14:0], spi_sdo};
          end
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
        A_HOLD, D_HOLD: if (r_cnt == GAP_END) begin
          r_cnt <= '0;
          if (r_state == A_HOLD) begin
            r_cs_a  <= 1'b1;
            r_state <= A_GAP;
          end else begin
            r_cs_d  <= 1'b1;
            r_state <= D_GAP;
          end
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
        A_GAP: if (r_cnt == GAP_END) begin
          r_cnt   <= '0;
          r_cs_d  <= 1'b0;
          r_tx    <= r_wdata;
          r_sdi   <= r_wdata[15];
          r_state <= D_SETUP;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
        D_GAP: if (r_cnt == GAP_END) begin
          r_cnt   <= '0;
          r_rsp   <= 1'b1;
          r_state <= DONE;
          if (r_rw) r_rdata <= r_rx;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
